// File: rtl/vpu_sched_pkg.sv
// Shared constants for the VPU frame scheduler: state encoding and widths.
package vpu_sched_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_PRIME  = 2'd1;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 2'd2;
  localparam logic [STATE_W-1:0] ST_VBLANK = 2'd3;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/vpu_frame_scheduler_vblank_timer.sv
// Loadable saturating down-counter that times the vertical-blank window.
module vblank_window_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] remaining,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Load has priority; otherwise count down each cycle and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign remaining = count_r;
  assign zero      = (count_r == {W{1'b0}});

endmodule

// File: rtl/vpu_frame_scheduler.sv
// Frame-level sequencer: primes the background FIFO, gates the pixel counter
// during active video, runs the vertical-blank CPU update window and commits
// double-buffer swaps at frame boundaries.
import vpu_sched_pkg::*;

module vpu_frame_scheduler #(
  parameter int FIFO_AW           = 9,
  parameter int PRIME_LEVEL       = 256,
  parameter int VBLANK_CYCLES     = 1024,
  parameter int MIN_UPDATE_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 pixel_ready,
  input  logic                 bg_fifo_empty,
  input  logic [FIFO_AW:0]     bg_fifo_level,
  input  logic                 new_frame,
  input  logic                 cpu_update_req,
  input  logic                 cpu_update_done,
  input  logic                 swap_req,
  input  logic                 underrun_clr,
  output logic                 counter_enable,
  output logic                 fetch_enable,
  output logic                 update_grant,
  output logic                 buffer_select,
  output logic [15:0]          frame_count,
  output logic                 underrun,
  output logic [STATE_W-1:0]   state_o
);

  localparam int LW = FIFO_AW + 1;
  localparam int TW = $clog2(VBLANK_CYCLES + 1);

  localparam logic [LW-1:0] PRIME_LVL_C  = LW'(PRIME_LEVEL);
  localparam logic [TW-1:0] WIN_LOAD_C   = TW'(VBLANK_CYCLES - 1);
  localparam logic [TW-1:0] MIN_UPD_C    = TW'(MIN_UPDATE_CYCLES);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] state_nxt_s;
  logic               fetch_enable_r;
  logic               grant_r;
  logic               buffer_select_r;
  logic [15:0]        frame_count_r;
  logic               underrun_r;
  logic               swap_pending_r;

  logic               win_load_s;
  logic [TW-1:0]      win_remaining_s;
  logic               win_zero_s;
  logic               vblank_exit_s;
  logic               grant_issue_s;
  logic               underrun_set_s;

  vblank_window_timer #(
    .W(TW)
  ) u_window_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (win_load_s),
    .load_val  (WIN_LOAD_C),
    .remaining (win_remaining_s),
    .zero      (win_zero_s)
  );

  // Frame-boundary and window events derived from the current state.
  always_comb begin
    win_load_s     = 1'b0;
    vblank_exit_s  = 1'b0;
    grant_issue_s  = 1'b0;
    underrun_set_s = 1'b0;
    if (state_r == ST_ACTIVE) begin
      win_load_s     = new_frame;
      underrun_set_s = pixel_ready & bg_fifo_empty;
    end else if (state_r == ST_VBLANK) begin
      // An outstanding grant holds the window open past its nominal length.
      vblank_exit_s  = win_zero_s & ~grant_r;
      grant_issue_s  = cpu_update_req & ~grant_r & (win_remaining_s >= MIN_UPD_C);
    end else begin
      win_load_s     = 1'b0;
    end
  end

  // Next-state selection; run is only sampled outside active video.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) state_nxt_s = ST_PRIME;
        else     state_nxt_s = ST_IDLE;
      end
      ST_PRIME: begin
        if (!run)                            state_nxt_s = ST_IDLE;
        else if (bg_fifo_level >= PRIME_LVL_C) state_nxt_s = ST_ACTIVE;
        else                                 state_nxt_s = ST_PRIME;
      end
      ST_ACTIVE: begin
        if (new_frame) state_nxt_s = ST_VBLANK;
        else           state_nxt_s = ST_ACTIVE;
      end
      ST_VBLANK: begin
        if (vblank_exit_s) state_nxt_s = run ? ST_PRIME : ST_IDLE;
        else               state_nxt_s = ST_VBLANK;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Counter gating is combinational so a stalled FIFO freezes it the same cycle.
  always_comb begin
    counter_enable = 1'b0;
    if (state_r == ST_ACTIVE) begin
      counter_enable = pixel_ready & ~bg_fifo_empty;
    end else begin
      counter_enable = 1'b0;
    end
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      fetch_enable_r <= 1'b0;
      frame_count_r  <= 16'd0;
    end else begin
      state_r        <= state_nxt_s;
      fetch_enable_r <= (state_nxt_s != ST_IDLE);
      frame_count_r  <= win_load_s ? (frame_count_r + 16'd1) : frame_count_r;
    end
  end

  // CPU update grant: issued only with enough window left, dropped on done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_r <= 1'b0;
    end else if (grant_issue_s) begin
      grant_r <= 1'b1;
    end else if (grant_r && cpu_update_done) begin
      grant_r <= 1'b0;
    end else begin
      grant_r <= grant_r;
    end
  end

  // Buffer swap bookkeeping: requests collapse into one toggle at VBLANK exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_pending_r  <= 1'b0;
      buffer_select_r <= 1'b0;
    end else if (vblank_exit_s) begin
      swap_pending_r  <= 1'b0;
      buffer_select_r <= buffer_select_r ^ (swap_pending_r | swap_req);
    end else if (swap_req && (state_r != ST_IDLE)) begin
      swap_pending_r  <= 1'b1;
      buffer_select_r <= buffer_select_r;
    end else begin
      swap_pending_r  <= swap_pending_r;
      buffer_select_r <= buffer_select_r;
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_r <= 1'b0;
    end else if (underrun_set_s) begin
      underrun_r <= 1'b1;
    end else if (underrun_clr) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  assign fetch_enable  = fetch_enable_r;
  assign update_grant  = grant_r;
  assign buffer_select = buffer_select_r;
  assign frame_count   = frame_count_r;
  assign underrun      = underrun_r;
  assign state_o       = state_r;

endmodule
